// File: rtl/stream_arb_pkg.sv
// Shared constants and helpers for the stream arbiter and its per-channel FIFOs.
package stream_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int ch_bits(input int n);
        int b;
        b = $clog2(n);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/stream_arbiter_byte_fifo.sv
// Single-channel synchronous FIFO (module byte_fifo) with registered count, full and empty.
module byte_fifo
    import stream_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH, which is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// N-channel byte-stream arbiter: per-channel FIFOs feeding one registered valid/ready output.
// Optional almost_full hysteresis flags are built when STREAM_ARBITER_WATERMARK_EN is defined.
module stream_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ARB_MODE   = ARB_RR
`ifdef STREAM_ARBITER_WATERMARK_EN
    ,
    parameter int HI_WM      = FIFO_DEPTH - 1,
    parameter int LO_WM      = 1
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [NUM_CH*DATA_W-1:0]    in_data,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           in_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [ch_bits(NUM_CH)-1:0]  out_src,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef STREAM_ARBITER_WATERMARK_EN
    ,
    output logic [NUM_CH-1:0]           almost_full
`endif
);

    localparam int CH_BITS = ch_bits(NUM_CH);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CH-1:0]  full;
    logic [NUM_CH-1:0]  empty;
    logic [NUM_CH-1:0]  push;
    logic [NUM_CH-1:0]  pop;
    logic [DATA_W-1:0]  fifo_data  [NUM_CH];
    logic [CW-1:0]      fifo_count [NUM_CH];
    logic [CH_BITS-1:0] ptr;
    logic [CH_BITS-1:0] grant_idx;
    logic               grant_any;
    logic               load;

    // in_ready comes straight from the registered full flag, so a full FIFO
    // stays not-ready even in a cycle where it is being popped.
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign in_ready[g] = !full[g];
            assign push[g]     = in_valid[g] && !full[g];
            assign pop[g]      = load && !flush && (grant_idx == CH_BITS'(g));

            byte_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .flush   (flush),
                .wr_en   (in_valid[g]),
                .wr_data (in_data[g*DATA_W +: DATA_W]),
                .rd_en   (pop[g]),
                .rd_data (fifo_data[g]),
                .full    (full[g]),
                .empty   (empty[g]),
                .count   (fifo_count[g])
            );

            a_count_consistent: assert property (@(posedge clk) disable iff (!rst_n)
                (fifo_count[g] <= CW'(FIFO_DEPTH)) &&
                (full[g] == (fifo_count[g] == CW'(FIFO_DEPTH))));
        end
    endgenerate

    // Round-robin starts one past the last grant; fixed priority starts at channel 0.
    always_comb begin
        int idx;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == ARB_RR) begin
                idx = (int'(ptr) + 1 + k) % NUM_CH;
            end else begin
                idx = k;
            end
            if (!grant_any && !empty[idx]) begin
                grant_any = 1'b1;
                grant_idx = CH_BITS'(idx);
            end
        end
    end

    assign load = (!out_valid || out_ready) && grant_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= CH_BITS'(NUM_CH - 1);
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= CH_BITS'(NUM_CH - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= fifo_data[grant_idx];
            out_src   <= grant_idx;
            ptr       <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_ARBITER_WATERMARK_EN
    logic [CW-1:0] cnt_next [NUM_CH];

    // Flags follow the count the FIFO will hold after this edge, so they
    // change on the same edge the count crosses a watermark.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_next[i] = fifo_count[i];
            if (push[i] && !pop[i]) begin
                cnt_next[i] = fifo_count[i] + 1'b1;
            end else if (pop[i] && !push[i]) begin
                cnt_next[i] = fifo_count[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full <= '0;
        end else if (flush) begin
            almost_full <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_next[i] >= CW'(HI_WM)) begin
                    almost_full[i] <= 1'b1;
                end else if (cnt_next[i] <= CW'(LO_WM)) begin
                    almost_full[i] <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- Parametrised N-channel byte-stream arbiter and successor to the two-input keyboard/UART input multiplexer.
- Each source (keyboard, UART RX, future host/loopback channels) gets its own FIFO.
- One stream is granted per cycle to a single registered valid/ready output feeding command_handler.
- The output carries the source channel ID, so downstream logic can tell local keystrokes from host data.

Parameters:
- NUM_CH, 2, number of input channels (>=2).
- DATA_W, 8, bits per stream word.
- FIFO_DEPTH, 4, words per channel FIFO (power of 2, >=2).
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all FIFOs and the output register.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready; bit i = FIFO i not full.
- out_data  out  DATA_W  granted word.
- out_src  out  CH_BITS  channel index of out_data; CH_BITS = max(1, clog2(NUM_CH)).
- out_valid  out  1  output word present.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all FIFOs empty.
  - out_valid=0, out_data=0, out_src=0.
  - RR pointer = NUM_CH-1, so channel 0 is first to be granted.
  - in_ready = all ones, both during and after reset.
- Push: when in_valid[i] and in_ready[i] at a clk edge, the word is written to FIFO i.
  - in_ready is derived from the registered count only; there is no bypass, so a full FIFO stays not-ready even in a cycle where it pops.
- Pop/load: the output register loads when (!out_valid || out_ready) and any FIFO is non-empty.
  - The granted FIFO pops in the same cycle.
  - out_src = granted index.
  - If no FIFO is non-empty, out_valid clears on out_ready.
- Latency: a word accepted at edge k into an empty FIFO, with the output register free, shows out_valid=1 after edge k+1.
- Throughput: one word per cycle sustained while out_ready=1.
- Grant selection:
  - ARB_MODE=0: lowest-index non-empty FIFO wins.
  - ARB_MODE=1: search starts at (ptr+1) mod NUM_CH and wraps; after a grant, ptr = granted index. ptr does not change when nothing is granted.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_src hold.
- Simultaneous push and pop on one FIFO: count unchanged, data order preserved. Per-channel FIFO order is strictly preserved.
- Pointer/count widths:
  - Read/write pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
  - Count is clog2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- flush (synchronous):
  - empties all FIFOs, clears out_valid, resets ptr to NUM_CH-1.
  - takes priority over any push or pop in the same cycle; words presented that cycle are dropped.
- rst_n asserted mid-transfer: all state is discarded immediately; no partial word is emitted.

Optional Feature:
- Macro STREAM_ARBITER_WATERMARK_EN.
- Defined:
  - adds parameters HI_WM (default FIFO_DEPTH-1) and LO_WM (default 1).
  - adds output almost_full[NUM_CH-1:0], a registered hysteresis flag per channel, used to drive XOFF/XON toward the host.
  - Flag i sets on the edge where count_i becomes >= HI_WM, and clears when count_i becomes <= LO_WM.
  - Flags reset to 0 and are cleared by flush.
- Not defined: the parameters, port and logic are absent; all other behaviour is identical.

Decomposition:
- Package stream_arb_pkg:
  - localparams ARB_FIXED=0, ARB_RR=1.
  - function ch_bits(n) returning max(1, clog2(n)).
- Sub-module byte_fifo:
  - single-channel synchronous FIFO, parametrised DATA_W and DEPTH.
  - exposes full, empty and count.
  - instantiated NUM_CH times in a generate loop.
- Arbitration and the output register stay in the top module.

Test Plan:
- Reset then idle: in_ready=2'b11, out_valid=0, out_src=0. Push 8'h41 on ch0 at edge k -> out_valid=1, out_data=8'h41, out_src=0 after edge k+1.
- RR mode, both FIFOs preloaded (ch0: 01,02,03; ch1: A1,A2,A3), out_ready=1 -> output 01,A1,02,A2,03,A3 with out_src alternating 0,1.
- Fixed mode, same preload -> 01,02,03,A1,A2,A3.
- Backpressure: out_ready=0, push 5 words on ch1 with FIFO_DEPTH=4 -> one word held in the output register, FIFO fills, in_ready[1]=0. The 6th word is not accepted; after release all 5 emerge in order.
- flush asserted in the same cycle as push 8'h55 on ch0 -> 8'h55 dropped, out_valid=0 next cycle, all FIFOs empty, in_ready all ones.
- With STREAM_ARBITER_WATERMARK_EN, HI_WM=3, LO_WM=1, out_ready=0: fill ch0 to 3 -> almost_full[0]=1. Drain to 2 -> still 1. Drain to 1 -> 0.
